// File: rtl/ex_forward_unit_pkg.sv
// Shared types for the PRE_EX operand-forwarding producer: bypass select encoding,
// load-use FSM states and default widths.
package ex_forward_unit_pkg;

  localparam int FWD_REG_BITS = 5;
  localparam int FWD_DATA_W   = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lu_state_t;

  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ex_forward_unit_fwd_match.sv
// Resolves one ID source register against the EX/MEM/WB producers and the retired-write
// history, returning the winning bypass select/data or a load-use hazard.
module fwd_match
  import ex_forward_unit_pkg::*;
#(
  parameter int width      = FWD_DATA_W,
  parameter int REG_BITS   = FWD_REG_BITS,
  parameter int HIST_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic [REG_BITS-1:0]                  rs,
  input  logic                                 used,
  input  logic                                 ex_valid,
  input  logic [REG_BITS-1:0]                  ex_rd,
  input  logic                                 ex_is_load,
  input  logic [width-1:0]                     ex_result,
  input  logic                                 mem_valid,
  input  logic [REG_BITS-1:0]                  mem_rd,
  input  logic [width-1:0]                     mem_result,
  input  logic                                 wb_valid,
  input  logic [REG_BITS-1:0]                  wb_rd,
  input  logic [width-1:0]                     wb_result,
  input  logic [HIST_DEPTH-1:0]                hist_valid,
  input  logic [HIST_DEPTH-1:0][REG_BITS-1:0]  hist_rd,
  input  logic [HIST_DEPTH-1:0][width-1:0]     hist_data,
  input  logic [PTR_W-1:0]                     hist_ptr,
  output logic                                 hit,
  output logic                                 hazard,
  output fwd_sel_t                             sel,
  output logic [width-1:0]                     data
);

  logic [PTR_W-1:0] idx;

  // Lowest priority is evaluated first so that later, higher-priority matches override it.
  always_comb begin
    hit    = 1'b0;
    hazard = 1'b0;
    sel    = FWD_RF;
    data   = '0;
    idx    = '0;
    if (used && rs != '0) begin
      // k = 0 is the newest entry (one behind the write pointer); walk oldest to newest
      for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
        idx = PTR_W'((int'(hist_ptr) + 2 * HIST_DEPTH - 1 - k) % HIST_DEPTH);
        if (hist_valid[idx] && hist_rd[idx] == rs) begin
          hit  = 1'b1;
          sel  = FWD_WB;
          data = hist_data[idx];
        end
      end
      if (wb_valid && wb_rd == rs) begin
        hit  = 1'b1;
        sel  = FWD_WB;
        data = wb_result;
      end
      if (mem_valid && mem_rd == rs) begin
        hit  = 1'b1;
        sel  = FWD_MEM;
        data = mem_result;
      end
      if (ex_valid && ex_rd == rs) begin
        if (ex_is_load) begin
          hit    = 1'b0;
          hazard = 1'b1;
          sel    = FWD_RF;
          data   = '0;
        end else begin
          hit  = 1'b1;
          sel  = FWD_EX;
          data = ex_result;
        end
      end
    end
  end

endmodule

// File: rtl/ex_forward_unit.sv
// Operand-forwarding producer for PRE_EX: registers per-source bypass select/data,
// keeps a small history of retired writes and raises the load-use stall.
module ex_forward_unit
  import ex_forward_unit_pkg::*;
#(
  parameter int width      = FWD_DATA_W,
  parameter int REG_BITS   = FWD_REG_BITS,
  parameter int HIST_DEPTH = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clkEn,
  input  logic                flush,
  input  logic                stall,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic                ex_valid,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_is_load,
  input  logic [width-1:0]    ex_result,
  input  logic                mem_valid,
  input  logic [REG_BITS-1:0] mem_rd,
  input  logic [width-1:0]    mem_result,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic [width-1:0]    wb_result,
  output logic [width-1:0]    forwardData1,
  output logic [width-1:0]    forwardData2,
  output logic [1:0]          forwardData1Reg,
  output logic [1:0]          forwardData2Reg,
  output logic                load_use_stall
);

  localparam int PTR_W = ptr_bits(HIST_DEPTH);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic [width-1:0]    data;
  } fwd_hist_entry_t;

  fwd_hist_entry_t                   hist [HIST_DEPTH];
  logic [PTR_W-1:0]                  wptr;
  logic [HIST_DEPTH-1:0]             hist_valid;
  logic [HIST_DEPTH-1:0][REG_BITS-1:0] hist_rd;
  logic [HIST_DEPTH-1:0][width-1:0]  hist_data;

  logic                hit1, hit2, hazard1, hazard2, hazard, advance;
  fwd_sel_t            sel1, sel2, sel1_p1, sel2_p1;
  logic [width-1:0]    data1, data2, data1_p1, data2_p1;
  lu_state_t           state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;

  always_comb begin
    for (int i = 0; i < HIST_DEPTH; i++) begin
      hist_valid[i] = hist[i].valid;
      hist_rd[i]    = hist[i].rd;
      hist_data[i]  = hist[i].data;
    end
  end

  fwd_match #(
    .width(width), .REG_BITS(REG_BITS), .HIST_DEPTH(HIST_DEPTH), .PTR_W(PTR_W)
  ) u_match1 (
    .rs(id_rs1), .used(id_rs1_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
    .hist_valid(hist_valid), .hist_rd(hist_rd), .hist_data(hist_data), .hist_ptr(wptr),
    .hit(hit1), .hazard(hazard1), .sel(sel1), .data(data1)
  );

  fwd_match #(
    .width(width), .REG_BITS(REG_BITS), .HIST_DEPTH(HIST_DEPTH), .PTR_W(PTR_W)
  ) u_match2 (
    .rs(id_rs2), .used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
    .hist_valid(hist_valid), .hist_rd(hist_rd), .hist_data(hist_data), .hist_ptr(wptr),
    .hit(hit2), .hazard(hazard2), .sel(sel2), .data(data2)
  );

  assign hazard = hazard1 | hazard2;

  // Load-use FSM: IDLE stalls combinationally on a hazard, WAIT covers the load latency.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    load_use_stall = 1'b0;
    case (state)
      ST_IDLE: begin
        load_use_stall = id_valid & hazard;
        if (clkEn && id_valid && hazard && !stall) begin
          state_n = ST_WAIT;
          cnt_n   = CNT_W'(LOAD_LAT);
        end
      end
      ST_WAIT: begin
        load_use_stall = 1'b1;
        if (clkEn) begin
          if (cnt <= CNT_W'(1)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (clkEn && flush) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign advance = clkEn & id_valid & ~stall & ~load_use_stall;

  // p0 -> p1: bypass select and data presented to PRE_EX one cycle after ID advances
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel1_p1  <= FWD_RF;
      sel2_p1  <= FWD_RF;
      data1_p1 <= '0;
      data2_p1 <= '0;
    end else if (clkEn && flush) begin
      sel1_p1  <= FWD_RF;
      sel2_p1  <= FWD_RF;
      data1_p1 <= '0;
      data2_p1 <= '0;
    end else if (advance) begin
      sel1_p1  <= hit1 ? sel1 : FWD_RF;
      sel2_p1  <= hit2 ? sel2 : FWD_RF;
      data1_p1 <= hit1 ? data1 : '0;
      data2_p1 <= hit2 ? data2 : '0;
    end
  end

  // Retired writes are architectural, so history ignores stall, flush and load-use holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
      wptr <= '0;
    end else if (clkEn && wb_valid && wb_rd != '0) begin
      hist[wptr] <= '{valid: 1'b1, rd: wb_rd, data: wb_result};
      wptr       <= (wptr == PTR_W'(HIST_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
    end
  end

  assign forwardData1    = data1_p1;
  assign forwardData2    = data2_p1;
  assign forwardData1Reg = sel1_p1;
  assign forwardData2Reg = sel2_p1;

endmodule

// File: tb/tb_ex_forward_unit.sv
// Bench for ex_forward_unit: directed scenarios plus randomized traffic against a
// queue-based model of the forwarding rules.
module tb_ex_forward_unit;

  localparam int W  = 32;
  localparam int RB = 5;
  localparam int HD = 2;
  localparam int LL = 1;

  logic          clk = 1'b0;
  logic          rst, clkEn, flush, stall, id_valid;
  logic [RB-1:0] id_rs1, id_rs2;
  logic          id_rs1_used, id_rs2_used;
  logic          ex_valid, ex_is_load, mem_valid, wb_valid;
  logic [RB-1:0] ex_rd, mem_rd, wb_rd;
  logic [W-1:0]  ex_result, mem_result, wb_result;
  logic [W-1:0]  forwardData1, forwardData2;
  logic [1:0]    forwardData1Reg, forwardData2Reg;
  logic          load_use_stall;

  int errors = 0;
  int checks = 0;

  // model history: newest retired write at the front
  logic [RB+W-1:0] hq[$];

  always #5 clk = ~clk;

  ex_forward_unit #(.width(W), .REG_BITS(RB), .HIST_DEPTH(HD), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .flush(flush), .stall(stall),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
    .forwardData1(forwardData1), .forwardData2(forwardData2),
    .forwardData1Reg(forwardData1Reg), .forwardData2Reg(forwardData2Reg),
    .load_use_stall(load_use_stall)
  );

  task automatic tick();
    @(posedge clk);
    if (!rst) hq.delete();
    else if (clkEn && wb_valid && wb_rd != '0) begin
      hq.push_front({wb_rd, wb_result});
      if (hq.size() > HD) void'(hq.pop_back());
    end
    #1;
  endtask

  task automatic drive_idle();
    clkEn = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; ex_rd = '0; ex_is_load = 1'b0; ex_result = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_result = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  function automatic void ref_lookup(input logic [RB-1:0] rs, input logic used,
                                     output logic [1:0] sel, output logic [W-1:0] d);
    sel = 2'b00; d = '0;
    if (!used || rs == '0) return;
    if (ex_valid && ex_rd == rs) begin
      if (!ex_is_load) begin sel = 2'b01; d = ex_result; end
      return;
    end
    if (mem_valid && mem_rd == rs) begin sel = 2'b10; d = mem_result; return; end
    if (wb_valid && wb_rd == rs) begin sel = 2'b11; d = wb_result; return; end
    foreach (hq[i]) begin
      if (hq[i][RB+W-1:W] == rs) begin sel = 2'b11; d = hq[i][W-1:0]; return; end
    end
  endfunction

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'h1234; wb_valid = 1'b1; wb_rd = 5'd4;
    tick(); tick();
    checks++; if (forwardData1Reg !== 2'b00) begin errors++; $display("FAIL reset_sel1 got=%0h exp=0", forwardData1Reg); end
    checks++; if (forwardData2Reg !== 2'b00) begin errors++; $display("FAIL reset_sel2 got=%0h exp=0", forwardData2Reg); end
    checks++; if (forwardData1 !== '0) begin errors++; $display("FAIL reset_d1 got=%0h exp=0", forwardData1); end
    checks++; if (forwardData2 !== '0) begin errors++; $display("FAIL reset_d2 got=%0h exp=0", forwardData2); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", load_use_stall); end
    rst = 1'b1;
    drive_idle();
  endtask

  task automatic test_ex_forward();
    drive_idle();
    ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'hAAAA;
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    tick();
    checks++; if (forwardData1Reg !== 2'b01) begin errors++; $display("FAIL ex_sel1 got=%0h exp=1", forwardData1Reg); end
    checks++; if (forwardData1 !== 32'hAAAA) begin errors++; $display("FAIL ex_d1 got=%0h exp=aaaa", forwardData1); end
  endtask

  task automatic test_priority();
    drive_idle();
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    ex_valid = 1'b1; ex_rd = 5'd7; ex_result = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_result = 32'h2;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_result = 32'h3;
    tick();
    checks++; if (forwardData1Reg !== 2'b01) begin errors++; $display("FAIL prio_ex_sel got=%0h exp=1", forwardData1Reg); end
    checks++; if (forwardData1 !== 32'h1) begin errors++; $display("FAIL prio_ex_d got=%0h exp=1", forwardData1); end
    ex_valid = 1'b0;
    tick();
    checks++; if (forwardData1Reg !== 2'b10) begin errors++; $display("FAIL prio_mem_sel got=%0h exp=2", forwardData1Reg); end
    checks++; if (forwardData1 !== 32'h2) begin errors++; $display("FAIL prio_mem_d got=%0h exp=2", forwardData1); end
    drive_idle();
  endtask

  task automatic test_load_use();
    drive_idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    id_valid = 1'b1; id_rs2 = 5'd3; id_rs2_used = 1'b1;
    @(negedge clk);
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c0 got=%0b exp=1", load_use_stall); end
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    @(negedge clk);
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c1 got=%0b exp=1", load_use_stall); end
    tick();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_result = 32'h55;
    @(negedge clk);
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_c2 got=%0b exp=0", load_use_stall); end
    tick();
    checks++; if (forwardData2Reg !== 2'b10) begin errors++; $display("FAIL lu_sel2 got=%0h exp=2", forwardData2Reg); end
    checks++; if (forwardData2 !== 32'h55) begin errors++; $display("FAIL lu_d2 got=%0h exp=55", forwardData2); end
    drive_idle();
  endtask

  task automatic test_history();
    drive_idle();
    rst = 1'b0; tick(); rst = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd1; wb_result = 32'h11; tick();
    wb_rd = 5'd2; wb_result = 32'h22; tick();
    wb_rd = 5'd3; wb_result = 32'h33; tick();
    wb_valid = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_used = 1'b1; id_rs2 = 5'd3; id_rs2_used = 1'b1;
    tick();
    checks++; if (forwardData1Reg !== 2'b00) begin errors++; $display("FAIL hist_r1_sel got=%0h exp=0", forwardData1Reg); end
    checks++; if (forwardData2Reg !== 2'b11) begin errors++; $display("FAIL hist_r3_sel got=%0h exp=3", forwardData2Reg); end
    checks++; if (forwardData2 !== 32'h33) begin errors++; $display("FAIL hist_r3_d got=%0h exp=33", forwardData2); end
    id_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2; wb_result = 32'h99; tick();
    wb_valid = 1'b0; id_valid = 1'b1; id_rs1 = 5'd2;
    tick();
    checks++; if (forwardData1Reg !== 2'b11) begin errors++; $display("FAIL hist_r2_sel got=%0h exp=3", forwardData1Reg); end
    checks++; if (forwardData1 !== 32'h99) begin errors++; $display("FAIL hist_r2_d got=%0h exp=99", forwardData1); end
    id_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2; wb_result = 32'h77; tick();
    wb_valid = 1'b0; id_valid = 1'b1;
    tick();
    checks++; if (forwardData1 !== 32'h77) begin errors++; $display("FAIL hist_newest_d got=%0h exp=77", forwardData1); end
    checks++; if (forwardData2Reg !== 2'b00) begin errors++; $display("FAIL hist_evict_sel got=%0h exp=0", forwardData2Reg); end
    drive_idle();
  endtask

  task automatic test_zero_and_clken();
    drive_idle();
    ex_valid = 1'b1; ex_rd = 5'd0; ex_result = 32'h1234;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_result = 32'h66;
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
    tick();
    checks++; if (forwardData1Reg !== 2'b00) begin errors++; $display("FAIL r0_sel got=%0h exp=0", forwardData1Reg); end
    checks++; if (forwardData1 !== '0) begin errors++; $display("FAIL r0_d got=%0h exp=0", forwardData1); end
    checks++; if (forwardData2 !== 32'h66) begin errors++; $display("FAIL mem_d got=%0h exp=66", forwardData2); end
    clkEn = 1'b0;
    id_rs1 = 5'd5; id_rs2 = 5'd5; ex_rd = 5'd5; ex_result = 32'hAAAA;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_result = 32'h44;
    tick(); tick();
    checks++; if (forwardData1Reg !== 2'b00) begin errors++; $display("FAIL clken_sel1 got=%0h exp=0", forwardData1Reg); end
    checks++; if (forwardData2Reg !== 2'b10) begin errors++; $display("FAIL clken_sel2 got=%0h exp=2", forwardData2Reg); end
    checks++; if (forwardData2 !== 32'h66) begin errors++; $display("FAIL clken_d2 got=%0h exp=66", forwardData2); end
    clkEn = 1'b1; wb_valid = 1'b0; ex_valid = 1'b0; mem_valid = 1'b0;
    id_rs1 = 5'd4; id_rs2 = 5'd2;
    tick();
    checks++; if (forwardData1Reg !== 2'b00) begin errors++; $display("FAIL clken_nohist_sel got=%0h exp=0", forwardData1Reg); end
    checks++; if (forwardData2 !== 32'h77) begin errors++; $display("FAIL clken_hist_d got=%0h exp=77", forwardData2); end
    drive_idle();
  endtask

  task automatic test_flush_wait();
    drive_idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL flush_wait_stall got=%0b exp=1", load_use_stall); end
    flush = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; id_valid = 1'b0;
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", load_use_stall); end
    checks++; if (forwardData2Reg !== 2'b00) begin errors++; $display("FAIL flush_sel2 got=%0h exp=0", forwardData2Reg); end
    checks++; if (forwardData2 !== '0) begin errors++; $display("FAIL flush_d2 got=%0h exp=0", forwardData2); end
    id_valid = 1'b1; id_rs1 = 5'd2; id_rs1_used = 1'b1;
    tick();
    checks++; if (forwardData1Reg !== 2'b11) begin errors++; $display("FAIL flush_hist_sel got=%0h exp=3", forwardData1Reg); end
    checks++; if (forwardData1 !== 32'h77) begin errors++; $display("FAIL flush_hist_d got=%0h exp=77", forwardData1); end
    // reset while the load-use stall is active
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    tick();
    @(negedge clk);
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL rst_wait_stall got=%0b exp=1", load_use_stall); end
    rst = 1'b0; id_valid = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    tick();
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", load_use_stall); end
    checks++; if (forwardData1Reg !== 2'b00) begin errors++; $display("FAIL rst_sel1 got=%0h exp=0", forwardData1Reg); end
    checks++; if (forwardData1 !== '0) begin errors++; $display("FAIL rst_d1 got=%0h exp=0", forwardData1); end
    rst = 1'b1;
    drive_idle();
  endtask

  task automatic test_random();
    logic [1:0]   s1, s2, e1s, e2s;
    logic [W-1:0] d1, d2, e1d, e2d;
    drive_idle();
    rst = 1'b0; tick(); rst = 1'b1;
    e1s = 2'b00; e2s = 2'b00; e1d = '0; e2d = '0;
    repeat (300) begin
      clkEn       = ($urandom_range(0, 7) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      stall       = ($urandom_range(0, 5) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = RB'($urandom_range(0, 7));
      id_rs2      = RB'($urandom_range(0, 7));
      id_rs1_used = ($urandom_range(0, 4) != 0);
      id_rs2_used = ($urandom_range(0, 4) != 0);
      ex_valid    = $urandom_range(0, 1) == 1;
      ex_rd       = RB'($urandom_range(0, 7));
      ex_result   = $urandom;
      mem_valid   = $urandom_range(0, 1) == 1;
      mem_rd      = RB'($urandom_range(0, 7));
      mem_result  = $urandom;
      wb_valid    = $urandom_range(0, 1) == 1;
      wb_rd       = RB'($urandom_range(0, 7));
      wb_result   = $urandom;
      ref_lookup(id_rs1, id_rs1_used, s1, d1);
      ref_lookup(id_rs2, id_rs2_used, s2, d2);
      @(negedge clk);
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL rnd_stall got=%0b exp=0", load_use_stall); end
      if (clkEn) begin
        if (flush) begin e1s = 2'b00; e2s = 2'b00; e1d = '0; e2d = '0; end
        else if (id_valid && !stall) begin e1s = s1; e2s = s2; e1d = d1; e2d = d2; end
      end
      tick();
      checks++; if (forwardData1Reg !== e1s) begin errors++; $display("FAIL rnd_sel1 got=%0h exp=%0h", forwardData1Reg, e1s); end
      checks++; if (forwardData1 !== e1d) begin errors++; $display("FAIL rnd_d1 got=%0h exp=%0h", forwardData1, e1d); end
      checks++; if (forwardData2Reg !== e2s) begin errors++; $display("FAIL rnd_sel2 got=%0h exp=%0h", forwardData2Reg, e2s); end
      checks++; if (forwardData2 !== e2d) begin errors++; $display("FAIL rnd_d2 got=%0h exp=%0h", forwardData2, e2d); end
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_history();
    test_zero_and_clken();
    test_flush_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
